uctl_bank_req_arb: RTL and testbench
====================================

# uctl_bank_req_arb

Request arbiter driving the one-hot `uctl_chipsel` of the memory client mux for one buffer bank. Takes level requests from four clients and selects one at a time with round-robin fairness. A granted client keeps the bank for a bounded burst. The arbiter also receives the mux's registered read-data-valid acknowledge and forwards it per client, optionally checking it against the grant history.

## Interface
- `NUM_CL`, 4, number of clients; fixed at 4 (one-hot `uctl_chipsel` width).
- `MAX_BURST`, 4, maximum consecutive beats per tenure, ≥1; counter width `$clog2(MAX_BURST)` (min 1).

Ports:
- `uctl_clk` in 1: clock.
- `uctl_core_rst` in 1: reset, synchronous, active-high.
- `uctl_clReq` in 4: per-client request level; high in a grant cycle means "want another beat".
- `uctl_chipsel` out 4: registered one-hot bank select to the mux; all-zero when idle.
- `uctl_clGnt` out 4: equals `uctl_chipsel`; each high cycle is one beat (address/data sampled by mux).
- `uctl_clLast` out 4: high with `uctl_clGnt` on a beat forced to be final by `MAX_BURST`.
- `uctl_rdDVl` in 4: acknowledge from mux, `uctl_chipsel` delayed one cycle.
- `uctl_clRdVld` out 4: per-client read-data-valid, forwarded to clients.
- `uctl_arbErr` out 1: sticky acknowledge-mismatch flag.

## Operation
- State: `sel_q` (one-hot, drives `uctl_chipsel`), `ptr_q` (2-bit round-robin start index), `cnt_q` (beats taken in current tenure).
- FSM: IDLE (`sel_q`==0) / OWN (`sel_q` one-hot). No other states.
- IDLE: if any `uctl_clReq`, next `sel_q` = first requester searching `ptr_q`, `ptr_q`+1, … mod 4; `cnt_q`←0. Otherwise stay IDLE.
- OWN with owner k, every clock:
  - continue if `uctl_clReq[k]` and `cnt_q` < `MAX_BURST`-1: `sel_q` unchanged, `cnt_q`++.
  - otherwise the tenure ends: `ptr_q`←k+1 mod 4, and a new pick is made in the same edge, searching from k+1 over current requests (k itself is eligible last). The result goes to `sel_q` (a new tenure with `cnt_q`←0) or to 0 (IDLE).
- Switching owners has no bubble. A sole requester is regranted back-to-back with a fresh count.
- `uctl_clLast[k]` = `sel_q[k]` & (`cnt_q`==`MAX_BURST`-1). The client must treat that beat as the end of its tenure.
- `uctl_clRdVld` = `uctl_rdDVl` (masked per Configuration).
- A request withdrawn while not granted is simply not selected. Requests are never latched.

## Timing
- Reset values: `uctl_chipsel`/`uctl_clGnt`/`uctl_clLast` = 0, `uctl_clRdVld` = 0 (input-driven; the mux also resets), `uctl_arbErr` = 0, `ptr_q` = 0, `cnt_q` = 0.
- With `ptr_q`=0, the first pick after reset favours client 0.
- Request-to-grant latency: `uctl_clReq` high at edge N gives grant in cycle N+1 (one register).
- Grant-to-read-valid: `uctl_clRdVld[k]` high in the cycle after the `uctl_clGnt[k]` beat.
- Last beat: a client lowers `uctl_clReq` during its final grant cycle. `uctl_chipsel` moves on at the next edge.
- Reset asserted mid-tenure: `uctl_chipsel` is 0 at the next edge, and the counter and pointer are cleared. Beats in flight are dropped and clients must re-request.

## Configuration
- `UCTL_BANK_ARB_CHK_EN` defined:
  - an internal register `exp_q` ← `sel_q` each clock (reset 0).
  - `uctl_clRdVld` = `uctl_rdDVl` & `exp_q`.
  - `uctl_arbErr` is set when `uctl_rdDVl` != `exp_q`, and clears only on reset.
- Undefined: `uctl_clRdVld` = `uctl_rdDVl`, `uctl_arbErr` tied 0, and `exp_q` is absent.

## Structure
- Shared package `uctl_bank_pkg` holds:
  - `UCTL_NUM_CL`=4.
  - one-hot constants `UCTL_CS_CL0`..`UCTL_CS_CL3` (4'b0001..4'b1000) and `UCTL_CS_NONE`.
  - the same constants are reused by the mux.
- Sub-module `uctl_rr_pick`: combinational rotating-priority picker (4-bit req, 2-bit start → 4-bit one-hot, zero if no request). The arbiter instantiates it once.

## Test plan
- Reset then `uctl_clReq`=4'b1111 held → `uctl_chipsel` sequence 0001×4, 0010×4, 0100×4, 1000×4, 0001…; `uctl_clLast` on the 4th beat of each tenure.
- Only client 2 requests, held 10 cycles → chipsel 0100 for 10 consecutive cycles with no bubble; `uctl_clLast[2]` on beats 4 and 8.
- Client 1 requests 2 beats (drops req in its 2nd grant cycle) while client 3 waits → 0010, 0010, 1000 …; `ptr_q` after the switch = 2.
- Reset asserted in the middle of a client 0 burst (beat 2) → `uctl_chipsel`=0 at the next edge. After release, with `uctl_clReq`=4'b1010, the first grant is 0010.
- CHK_EN: drive `uctl_rdDVl`=4'b0100 one cycle after chipsel 0001 → `uctl_clRdVld`=0, `uctl_arbErr`=1 and stays 1 until reset. A correct 0001 acknowledge → `uctl_clRdVld`=0001, no error.
- MAX_BURST=1, all requesting → owner rotates every cycle, `uctl_clLast` equals `uctl_chipsel` on every beat.

Source files
------------

// File: rtl/uctl_bank_pkg.sv
// rtl/uctl_bank_pkg.sv - shared client count and one-hot chip-select constants for the bank arbiter and mux
package uctl_bank_pkg;

    localparam int UCTL_NUM_CL = 4;

    typedef logic [1:0] uctl_cl_idx_t;

    localparam logic [UCTL_NUM_CL-1:0] UCTL_CS_NONE = 4'b0000;
    localparam logic [UCTL_NUM_CL-1:0] UCTL_CS_CL0  = 4'b0001;
    localparam logic [UCTL_NUM_CL-1:0] UCTL_CS_CL1  = 4'b0010;
    localparam logic [UCTL_NUM_CL-1:0] UCTL_CS_CL2  = 4'b0100;
    localparam logic [UCTL_NUM_CL-1:0] UCTL_CS_CL3  = 4'b1000;

    // Index of the owner encoded in a one-hot chip select; zero for an idle select.
    function automatic uctl_cl_idx_t uctl_cs_to_idx(input logic [UCTL_NUM_CL-1:0] cs);
        uctl_cl_idx_t idx;
        idx = 2'd0;
        case (cs)
            UCTL_CS_CL1: idx = 2'd1;
            UCTL_CS_CL2: idx = 2'd2;
            UCTL_CS_CL3: idx = 2'd3;
            default:     idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/uctl_rr_pick.sv
// rtl/uctl_rr_pick.sv - combinational rotating-priority picker, one-hot result, zero when nobody requests
module uctl_rr_pick
    import uctl_bank_pkg::*;
(
    input  logic [UCTL_NUM_CL-1:0] req_i,
    input  uctl_cl_idx_t           start_i,
    output logic [UCTL_NUM_CL-1:0] gnt_o
);

    // Walk start_i, start_i+1, ... (mod 4) and grant the first active request.
    always_comb begin
        logic [1:0] idx;
        logic       found;
        gnt_o = '0;
        found = 1'b0;
        idx   = start_i;
        for (int i = 0; i < UCTL_NUM_CL; i++) begin
            idx = start_i + 2'(i);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uctl_bank_req_arb.sv
// rtl/uctl_bank_req_arb.sv - round-robin bank request arbiter with bounded bursts; UCTL_BANK_ARB_CHK_EN adds acknowledge checking
module uctl_bank_req_arb
    import uctl_bank_pkg::*;
#(
    parameter int NUM_CL    = 4,
    parameter int MAX_BURST = 4
) (
    input  logic              uctl_clk,
    input  logic              uctl_core_rst,
    input  logic [NUM_CL-1:0] uctl_clReq,
    output logic [NUM_CL-1:0] uctl_chipsel,
    output logic [NUM_CL-1:0] uctl_clGnt,
    output logic [NUM_CL-1:0] uctl_clLast,
    input  logic [NUM_CL-1:0] uctl_rdDVl,
    output logic [NUM_CL-1:0] uctl_clRdVld,
    output logic              uctl_arbErr
);

    localparam int             CW       = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(MAX_BURST - 1);

    // The state is implied by sel_q: all-zero is IDLE, one-hot is OWN.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OWN  = 1'b1;

    logic [NUM_CL-1:0] sel_q, sel_d;
    uctl_cl_idx_t      ptr_q, ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [0:0]        state;
    uctl_cl_idx_t      owner;
    uctl_cl_idx_t      pick_start;
    logic [NUM_CL-1:0] pick;

    assign state = (sel_q != UCTL_CS_NONE) ? ST_OWN : ST_IDLE;
    assign owner = uctl_cs_to_idx(sel_q);

    uctl_rr_pick u_pick (
        .req_i   (uctl_clReq),
        .start_i (pick_start),
        .gnt_o   (pick)
    );

    // Next-state: keep the owner while it asks and has beats left, otherwise hand over in the same edge.
    always_comb begin
        sel_d      = sel_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        pick_start = ptr_q;
        case (state)
            ST_IDLE: begin
                pick_start = ptr_q;
                if (uctl_clReq != '0) begin
                    sel_d = pick;
                    cnt_d = '0;
                end
            end
            ST_OWN: begin
                // Searching from owner+1 makes the current owner eligible only last.
                pick_start = owner + 2'd1;
                if (((uctl_clReq & sel_q) != '0) && (cnt_q != CNT_LAST)) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    ptr_d = owner + 2'd1;
                    sel_d = pick;
                    cnt_d = '0;
                end
            end
            default: begin
                sel_d = UCTL_CS_NONE;
                cnt_d = '0;
            end
        endcase
    end

    // Arbitration registers; reset drops any tenure in progress.
    always_ff @(posedge uctl_clk) begin
        if (uctl_core_rst) begin
            sel_q <= UCTL_CS_NONE;
            ptr_q <= 2'd0;
            cnt_q <= '0;
        end else begin
            sel_q <= sel_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    assign uctl_chipsel = sel_q;
    assign uctl_clGnt   = sel_q;
    assign uctl_clLast  = sel_q & {NUM_CL{cnt_q == CNT_LAST}};

`ifdef UCTL_BANK_ARB_CHK_EN
    logic [NUM_CL-1:0] exp_q;
    logic              err_q;

    // The mux acknowledges the select one cycle late, so remember what was selected and hold any mismatch.
    always_ff @(posedge uctl_clk) begin
        if (uctl_core_rst) begin
            exp_q <= '0;
            err_q <= 1'b0;
        end else begin
            exp_q <= sel_q;
            err_q <= err_q | (uctl_rdDVl != exp_q);
        end
    end

    assign uctl_clRdVld = uctl_rdDVl & exp_q;
    assign uctl_arbErr  = err_q;
`else
    assign uctl_clRdVld = uctl_rdDVl;
    assign uctl_arbErr  = 1'b0;
`endif

endmodule

// File: tb/tb_uctl_bank_req_arb.sv
// tb/tb_uctl_bank_req_arb.sv - scoreboard bench for uctl_bank_req_arb (MAX_BURST 4 and 1 instances)
module tb_uctl_bank_req_arb;

`ifdef UCTL_BANK_ARB_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        logic [3:0] cs;
        logic [3:0] last;
        logic [3:0] rdvld;
        logic       err;
        logic       chk_ptr;
        logic [1:0] ptr;
        logic       chk1;
        logic [3:0] cs1;
        logic [3:0] last1;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_r = 1'b1;
    logic [3:0] req_r = 4'b0000;
    logic       force_en = 1'b0;
    logic [3:0] force_val = 4'b0000;

    logic [3:0] cs0, gnt0, last0, rdv0, rdvld0, mux0;
    logic       err0;
    logic [3:0] cs1, gnt1, last1, rdv1, rdvld1, mux1;
    logic       err1;

    exp_t       sbq[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic [3:0] prev_cs = 4'b0000;

    logic       chk1_g = 1'b0;
    logic [3:0] ecs1_g = 4'b0000;
    logic [3:0] elast1_g = 4'b0000;
    logic       chkptr_g = 1'b0;
    logic [1:0] eptr_g = 2'd0;

    always #5 clk = ~clk;

    uctl_bank_req_arb #(.NUM_CL(4), .MAX_BURST(4)) dut0 (
        .uctl_clk      (clk),
        .uctl_core_rst (rst_r),
        .uctl_clReq    (req_r),
        .uctl_chipsel  (cs0),
        .uctl_clGnt    (gnt0),
        .uctl_clLast   (last0),
        .uctl_rdDVl    (rdv0),
        .uctl_clRdVld  (rdvld0),
        .uctl_arbErr   (err0)
    );

    uctl_bank_req_arb #(.NUM_CL(4), .MAX_BURST(1)) dut1 (
        .uctl_clk      (clk),
        .uctl_core_rst (rst_r),
        .uctl_clReq    (req_r),
        .uctl_chipsel  (cs1),
        .uctl_clGnt    (gnt1),
        .uctl_clLast   (last1),
        .uctl_rdDVl    (rdv1),
        .uctl_clRdVld  (rdvld1),
        .uctl_arbErr   (err1)
    );

    // Mux model: registered chip select returned as the acknowledge.
    always @(posedge clk) begin
        if (rst_r) begin
            mux0 <= 4'b0000;
            mux1 <= 4'b0000;
        end else begin
            mux0 <= cs0;
            mux1 <= cs1;
        end
    end

    assign rdv0 = force_en ? force_val : mux0;
    assign rdv1 = mux1;

    task automatic chk4(input string nm, input string what, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s %s: got %b expected %b", nm, what, act, exp);
        end
    endtask

    // Monitor: pop one expectation per edge and compare the settled outputs.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk4(e.name, "chipsel", cs0, e.cs);
            chk4(e.name, "clGnt", gnt0, e.cs);
            chk4(e.name, "clLast", last0, e.last);
            chk4(e.name, "clRdVld", rdvld0, e.rdvld);
            chk4(e.name, "arbErr", {3'b000, err0}, {3'b000, e.err});
            if (e.chk_ptr) chk4(e.name, "ptr_q", {2'b00, dut0.ptr_q}, {2'b00, e.ptr});
            if (e.chk1) begin
                chk4(e.name, "b1_chipsel", cs1, e.cs1);
                chk4(e.name, "b1_clLast", last1, e.last1);
            end
        end
    end

    task automatic step(input logic [3:0] req, input logic rst, input logic frc, input logic [3:0] fv,
                        input logic [3:0] ecs, input logic [3:0] elast, input logic eerr, input string nm);
        exp_t e;
        @(negedge clk);
        req_r     = req;
        rst_r     = rst;
        force_en  = frc;
        force_val = fv;
        @(posedge clk);
        #1;
        e.cs    = ecs;
        e.last  = elast;
        if (rst)      e.rdvld = 4'b0000;
        else if (frc) e.rdvld = CHK ? (fv & prev_cs) : fv;
        else          e.rdvld = prev_cs;
        e.err     = CHK ? eerr : 1'b0;
        e.chk_ptr = chkptr_g;
        e.ptr     = eptr_g;
        e.chk1    = chk1_g;
        e.cs1     = ecs1_g;
        e.last1   = elast1_g;
        e.name    = nm;
        sbq.push_back(e);
        prev_cs = rst ? 4'b0000 : ecs;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [3:0] ecs, el;

        // Reset state on both instances.
        chk1_g = 1'b1; ecs1_g = 4'b0000; elast1_g = 4'b0000;
        step(4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, "reset0");
        step(4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, "reset1");

        // All four requesting: 4-beat tenures rotating 0,1,2,3,0; MAX_BURST=1 rotates every beat.
        for (int i = 0; i < 17; i++) begin
            ecs      = 4'b0001 << ((i / 4) % 4);
            el       = ((i % 4) == 3) ? ecs : 4'b0000;
            ecs1_g   = 4'b0001 << (i % 4);
            elast1_g = ecs1_g;
            step(4'b1111, 1'b0, 1'b0, 4'b0000, ecs, el, 1'b0, "rr_all");
        end

        // Sole requester client 2 for 10 beats: no bubble, last on beats 4 and 8.
        ecs1_g = 4'b0000; elast1_g = 4'b0000;
        step(4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, "c_reset");
        ecs1_g = 4'b0100; elast1_g = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            el = (i == 3 || i == 7) ? 4'b0100 : 4'b0000;
            step(4'b0100, 1'b0, 1'b0, 4'b0000, 4'b0100, el, 1'b0, "sole_cl2");
        end
        ecs1_g = 4'b0000; elast1_g = 4'b0000;
        step(4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, "sole_drop");

        // Client 1 takes two beats while client 3 waits; pointer lands on 2.
        chk1_g = 1'b0;
        step(4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, "d_reset");
        step(4'b1010, 1'b0, 1'b0, 4'b0000, 4'b0010, 4'b0000, 1'b0, "cl1_beat1");
        step(4'b1010, 1'b0, 1'b0, 4'b0000, 4'b0010, 4'b0000, 1'b0, "cl1_beat2");
        chkptr_g = 1'b1; eptr_g = 2'd2;
        step(4'b1000, 1'b0, 1'b0, 4'b0000, 4'b1000, 4'b0000, 1'b0, "switch_cl3");
        step(4'b1000, 1'b0, 1'b0, 4'b0000, 4'b1000, 4'b0000, 1'b0, "cl3_beat2");
        chkptr_g = 1'b0;

        // Acknowledge check, sticky error, then reset in the middle of a client 0 burst.
        step(4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, "e_reset");
        step(4'b0001, 1'b0, 1'b0, 4'b0000, 4'b0001, 4'b0000, 1'b0, "ack_b1");
        step(4'b0001, 1'b0, 1'b0, 4'b0000, 4'b0001, 4'b0000, 1'b0, "ack_good");
        step(4'b0001, 1'b0, 1'b1, 4'b0100, 4'b0001, 4'b0000, 1'b1, "ack_bad");
        step(4'b0001, 1'b0, 1'b0, 4'b0000, 4'b0001, 4'b0001, 1'b1, "err_sticky1");
        step(4'b0001, 1'b0, 1'b0, 4'b0000, 4'b0001, 4'b0000, 1'b1, "err_sticky2");
        step(4'b0001, 1'b0, 1'b0, 4'b0000, 4'b0001, 4'b0000, 1'b1, "burst_beat2");
        step(4'b0001, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, "mid_reset");
        step(4'b1010, 1'b0, 1'b0, 4'b0000, 4'b0010, 4'b0000, 1'b0, "post_reset");
        step(4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, "idle");

        repeat (3) @(posedge clk);
        #3;
        n_vec++;
        if (sbq.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expectations expected 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
